// File: rtl/par_tx_pkg.sv
// Shared types and width helpers for the parity frame transmitter.
package par_tx_pkg;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    STOP2
  } state_e;

  // Counter width for a 0..range-1 count, never narrower than one bit.
  function automatic int cnt_w(input int range);
    return (range < 2) ? 1 : $clog2(range);
  endfunction
endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while en, bit_done on the terminal cycle.
// Latency: bit_done is combinational from the count; clr wins over en, no backpressure.
module bit_timer
  import par_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_done
);
  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_done = en && !clr && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/par_frame_tx.sv
// Serial even-parity frame transmitter (start, N data LSB first, parity, stop; PAR_FRAME_TX_STOP2_EN adds a 2nd stop).
// Latency: first start-bit cycle is the edge after capture; din_ready is low for the whole frame.
module par_frame_tx
  import par_tx_pkg::*;
#(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         tx,
  output logic         busy,
  output logic         par_o
);
  localparam int IW = cnt_w(N);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  state_e          state_q, state_d;
  logic [N-1:0]    shreg_q, shreg_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            rdy_q, rdy_d;
  logic            capture;
  logic            bit_done;

  assign capture   = rdy_q && din_valid;
  assign din_ready = rdy_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign par_o     = par_q;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (capture),
    .en       (state_q != IDLE),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = START;
          shreg_d = din;
          par_d   = ^din;
          idx_d   = '0;
        end
      end
      START:  if (bit_done) state_d = DATA;
      DATA: begin
        if (bit_done) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = PARITY;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      PARITY: if (bit_done) state_d = STOP;
`ifdef PAR_FRAME_TX_STOP2_EN
      STOP:   if (bit_done) state_d = STOP2;
      STOP2:  if (bit_done) state_d = IDLE;
`else
      STOP:   if (bit_done) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    rdy_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end
endmodule

// File: tb/tb_par_frame_tx.sv
// Scoreboard bench for par_frame_tx (N=8, CLKS_PER_BIT=4); honours PAR_FRAME_TX_STOP2_EN.
module tb_par_frame_tx;
  localparam int CPB = 4;
`ifdef PAR_FRAME_TX_STOP2_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif
  localparam int FC = (10 + NSTOP) * CPB;

  typedef struct {
    logic [10:0] bits;    // bit i is the i-th transmitted bit: start, d0..d7, parity, stop
    logic        par;
    int          period;  // expected start-to-start distance, 0 = unchecked
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       tx;
  logic       busy;
  logic       par_o;

  int     total = 0;
  int     bad   = 0;
  frame_t sb[$];

  par_frame_tx #(.N(8), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .tx        (tx),
    .busy      (busy),
    .par_o     (par_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [10:0] bits, input logic p);
    int n = 0;
    @(negedge clk);
    din       = d;
    din_valid = 1'b1;
    while (!din_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("send_ready_timeout", 64'(n), 0);
    sb.push_back('{bits, p, 0});
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("drain_timeout", 64'(n), 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: collects each frame from the first tx=0 cycle and checks it against the queue head.
  initial begin
    int          k = 0;
    int          cyc = 0;
    int          last_start = 0;
    int          period = 0;
    bit          in_frame = 0;
    bit          ok = 0;
    logic        prev_busy = 1'b0;
    logic        par_seen = 1'b0;
    logic [47:0] s = '0;
    logic [47:0] es;
    frame_t      e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        in_frame = 0;
      end else if (in_frame) begin
        if (k < FC) begin
          s[k] = tx;
          if (!busy || din_ready) ok = 0;
          k++;
        end else begin
          in_frame = 0;
          if (busy || !tx || !din_ready) ok = 0;
          chk("busy_window", 64'(ok), 1);
          if (sb.size() == 0) begin
            chk("unexpected_frame", 64'(sb.size()), 1);
          end else begin
            e  = sb.pop_front();
            es = '0;
            for (int i = 0; i < FC; i++) es[i] = e.bits[(i / CPB > 10) ? 10 : i / CPB];
            chk("frame_bits", 64'(s), 64'(es));
            chk("par_o", 64'(par_seen), 64'(e.par));
            if (e.period != 0) chk("frame_period", 64'(period), 64'(e.period));
          end
        end
      end else if (tx == 1'b0) begin
        in_frame   = 1;
        k          = 1;
        s          = '0;
        ok         = !prev_busy && busy && !din_ready;
        par_seen   = par_o;
        period     = cyc - last_start;
        last_start = cyc;
      end
      prev_busy = busy;
    end
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;

    // Reset state, held and after release
    repeat (3) @(negedge clk);
    chk("rst_tx", 64'(tx), 1);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ready", 64'(din_ready), 1);
    chk("rst_par", 64'(par_o), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rel_tx", 64'(tx), 1);
    chk("rel_busy", 64'(busy), 0);
    chk("rel_ready", 64'(din_ready), 1);
    chk("rel_par", 64'(par_o), 0);

    // 0xA5: four ones, parity 0
    send(8'hA5, 11'b1_0_10100101_0, 1'b0);
    drain();

    // 0x07: three ones, parity bit drives tx high
    send(8'h07, 11'b1_1_00000111_0, 1'b1);
    drain();

    // Back-to-back with din_valid held: 0x00 then 0xFF
    @(negedge clk);
    din       = 8'h00;
    din_valid = 1'b1;
    sb.push_back('{11'b1_0_00000000_0, 1'b0, 0});
    @(negedge clk);
    din = 8'hFF;
    sb.push_back('{11'b1_0_11111111_0, 1'b0, FC + 1});
    n = 0;
    while (!din_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("b2b_ready_timeout", 64'(n), 0);
    @(negedge clk);
    din_valid = 1'b0;
    drain();

    // Reset in the middle of data bit 3, then a clean frame
    send(8'h96, 11'b1_0_10010110_0, 1'b0);
    void'(sb.pop_back());
    repeat (17) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", 64'(tx), 1);
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_ready", 64'(din_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h3C, 11'b1_0_00111100_0, 1'b0);
    drain();

    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
